// File: rtl/fp_align_pipe_if.sv
// fp_align_pipe_if: operand/result bundle for the alignment pipe.
//   Input side : in_valid, in_ready, a_in, b_in (packed {sign, exp, mant})
//   Output side: out_valid, out_ready, swap, cancel, exp, moves,
//                sign_a, sign_b, a_mant, b_mant ({hidden, mant, G, R, S})
// The slave modport is the pipe's view; the master modport is the
// surrounding datapath's view (operand source and result sink).
interface fp_align_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       a_in;
  logic [W-1:0]       b_in;
  logic               out_valid;
  logic               out_ready;
  logic               swap;
  logic               cancel;
  logic [EXP_W-1:0]   exp;
  logic [EXP_W-1:0]   moves;
  logic               sign_a;
  logic               sign_b;
  logic [MAN_W+3:0]   a_mant;
  logic [MAN_W+3:0]   b_mant;

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, swap, cancel, exp, moves,
           sign_a, sign_b, a_mant, b_mant
  );

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, swap, cancel, exp, moves,
           sign_a, sign_b, a_mant, b_mant
  );
endinterface

// File: rtl/fp_align_pipe.sv
// fp_align_pipe: two-stage operand alignment for the FP adder datapath.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : fp_align_pipe_if.slave (operand handshake in, aligned result out)
// Stage 1 decodes both operands, orders them by exponent, computes the
// exponent difference and detects exact cancellation. Stage 2 right-shifts
// the smaller significand, collecting guard/round/sticky. Outputs come
// straight from the stage-2 registers; valid/ready backpressure is full,
// giving a capacity of two pairs.
// Build option: FP_ALIGN_SUBNORMAL_EN keeps subnormals (effective exponent 1,
// hidden bit 0); without it subnormals are flushed to signed zero.
module fp_align_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic           clk,
  input logic           rst,
  fp_align_pipe_if.slave bus
);
  localparam int          W     = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W = MAN_W + 1;

  // Effective exponent, significand with hidden bit, and the magnitude
  // used for cancellation after the subnormal policy has been applied.
  function automatic void f_decode(
    input  logic [W-1:0]     x,
    output logic [EXP_W-1:0] e,
    output logic [SIG_W-1:0] sig,
    output logic [W-2:0]     mag
  );
    logic [EXP_W-1:0] fe;
    logic [MAN_W-1:0] fm;
    fe = x[W-2:MAN_W];
    fm = x[MAN_W-1:0];
`ifdef FP_ALIGN_SUBNORMAL_EN
    e   = (fe == '0 && fm != '0) ? EXP_W'(1) : fe;
    sig = {(fe != '0), fm};
    mag = {fe, fm};
`else
    e   = fe;
    sig = (fe == '0) ? '0 : {1'b1, fm};
    mag = (fe == '0) ? '0 : {fe, fm};
`endif
  endfunction

  // stage-1 combinational
  logic             w_sa, w_sb;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [SIG_W-1:0] w_siga, w_sigb;
  logic [W-2:0]     w_maga, w_magb;
  logic             w_cancel, w_swap;
  logic [EXP_W-1:0] w_exp, w_moves;
  logic [SIG_W-1:0] w_big_sig, w_small_sig;
  logic             w_sign_a, w_sign_b;

  always_comb begin
    w_sa = bus.a_in[W-1];
    w_sb = bus.b_in[W-1];
    f_decode(bus.a_in, w_ea, w_siga, w_maga);
    f_decode(bus.b_in, w_eb, w_sigb, w_magb);

    w_cancel    = (w_maga == w_magb) && (w_sa != w_sb);
    w_swap      = !w_cancel && (w_eb > w_ea);
    w_exp       = w_ea;
    w_moves     = w_ea - w_eb;
    w_big_sig   = w_siga;
    w_small_sig = w_sigb;
    w_sign_a    = w_sa;
    w_sign_b    = w_sb;
    if (w_swap) begin
      w_exp       = w_eb;
      w_moves     = w_eb - w_ea;
      w_big_sig   = w_sigb;
      w_small_sig = w_siga;
      w_sign_a    = w_sb;
      w_sign_b    = w_sa;
    end
    if (w_cancel) begin
      w_exp       = '0;
      w_moves     = '0;
      w_big_sig   = '0;
      w_small_sig = '0;
    end
  end

  // stage-1 registers
  logic             r1_valid;
  logic             r1_swap, r1_cancel, r1_sign_a, r1_sign_b;
  logic [EXP_W-1:0] r1_exp, r1_moves;
  logic [SIG_W-1:0] r1_sig_a, r1_sig_b;

  // stage-2 combinational: {sig, G, R} shifted right, sticky collects every
  // significand bit that falls below R. A difference of MAN_W+3 or more
  // empties the {sig, G, R} field, leaving sticky = OR of the whole
  // significand.
  logic [SIG_W+1:0] w_sh_b;
  logic             w_sticky;

  always_comb begin
    w_sh_b   = {r1_sig_b, 2'b00} >> r1_moves;
    w_sticky = 1'b0;
    for (int unsigned i = 0; i < SIG_W; i++) begin
      if (r1_sig_b[i] && ((i + 32'd2) < 32'(r1_moves)))
        w_sticky = 1'b1;
    end
  end

  // stage-2 registers
  logic             r2_valid;
  logic             r2_swap, r2_cancel, r2_sign_a, r2_sign_b;
  logic [EXP_W-1:0] r2_exp, r2_moves;
  logic [MAN_W+3:0] r2_a_mant, r2_b_mant;

  logic w_adv2, w_in_ready, w_accept;
  assign w_adv2     = !r2_valid || bus.out_ready;
  assign w_in_ready = !r1_valid || w_adv2;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid  <= 1'b0;
      r1_swap   <= 1'b0;
      r1_cancel <= 1'b0;
      r1_sign_a <= 1'b0;
      r1_sign_b <= 1'b0;
      r1_exp    <= '0;
      r1_moves  <= '0;
      r1_sig_a  <= '0;
      r1_sig_b  <= '0;
      r2_valid  <= 1'b0;
      r2_swap   <= 1'b0;
      r2_cancel <= 1'b0;
      r2_sign_a <= 1'b0;
      r2_sign_b <= 1'b0;
      r2_exp    <= '0;
      r2_moves  <= '0;
      r2_a_mant <= '0;
      r2_b_mant <= '0;
    end else begin
      if (w_in_ready)
        r1_valid <= bus.in_valid;
      if (w_accept) begin
        r1_swap   <= w_swap;
        r1_cancel <= w_cancel;
        r1_sign_a <= w_sign_a;
        r1_sign_b <= w_sign_b;
        r1_exp    <= w_exp;
        r1_moves  <= w_moves;
        r1_sig_a  <= w_big_sig;
        r1_sig_b  <= w_small_sig;
      end
      if (w_adv2)
        r2_valid <= r1_valid;
      if (w_adv2 && r1_valid) begin
        r2_swap   <= r1_swap;
        r2_cancel <= r1_cancel;
        r2_sign_a <= r1_sign_a;
        r2_sign_b <= r1_sign_b;
        r2_exp    <= r1_exp;
        r2_moves  <= r1_moves;
        r2_a_mant <= {r1_sig_a, 3'b000};
        r2_b_mant <= {w_sh_b, w_sticky};
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r2_valid;
  assign bus.swap      = r2_swap;
  assign bus.cancel    = r2_cancel;
  assign bus.exp       = r2_exp;
  assign bus.moves     = r2_moves;
  assign bus.sign_a    = r2_sign_a;
  assign bus.sign_b    = r2_sign_b;
  assign bus.a_mant    = r2_a_mant;
  assign bus.b_mant    = r2_b_mant;
endmodule
